keystream_sequencer: RTL and testbench

KEYSTREAM_SEQUENCER -- requirements
Module: keystream_sequencer

---
 rtl/keystream_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_keystream_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keystream_sequencer.sv
// ============================================================================
// Module   : keystream_sequencer
// Purpose  : Controller for a coupled-map keystream datapath: seeds the maps,
//            discards warm-up iterations, then streams XOR-combined words over
//            a valid/ready handshake. Warm-up stage present only when the
//            macro KEYSTREAM_SEQ_WARMUP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keystream_sequencer #(
  parameter int WARMUP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [31:0] seed_p,
  input  logic [31:0] seed_s,
  input  logic [31:0] seed_l,
  input  logic [31:0] Xpn,
  input  logic [31:0] Xsn,
  input  logic [31:0] Xln,
  output logic        s,
  output logic        en1,
  output logic [31:0] Xp0,
  output logic [31:0] Xs0,
  output logic [31:0] Xl0,
  output logic [31:0] ks_word,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        busy,
  output logic        done
);

  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_warmup_range_check
    $error("keystream_sequencer: WARMUP_CYCLES must be within 1..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
`ifdef KEYSTREAM_SEQ_WARMUP_EN
    ST_WARMUP = 3'd2,
`endif
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_len;
  logic [31:0] r_seed_p;
  logic [31:0] r_seed_s;
  logic [31:0] r_seed_l;
  logic [31:0] r_shadow_p;
  logic [31:0] r_shadow_s;
  logic [31:0] r_shadow_l;
  logic [16:0] r_loaded;
  logic [16:0] r_sent;
  logic [31:0] r_ks_word;
  logic        r_ks_valid;

`ifdef KEYSTREAM_SEQ_WARMUP_EN
  localparam logic [7:0] c_warm_last = 8'(WARMUP_CYCLES - 1);
  logic [7:0]  r_warm_cnt;
`endif

  logic        w_adv;
  logic        w_hs;
  logic [16:0] w_len_ext;

  assign w_len_ext = {1'b0, r_len};
  assign w_adv     = (r_state == ST_RUN) && (!r_ks_valid || ks_ready) && (r_loaded < w_len_ext);
  assign w_hs      = r_ks_valid && ks_ready;

  assign ks_word  = r_ks_word;
  assign ks_valid = r_ks_valid;

  always_comb begin
    w_next_state = r_state;
    s            = 1'b0;
    en1          = 1'b0;
    Xp0          = 32'd0;
    Xs0          = 32'd0;
    Xl0          = 32'd0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (len != 16'd0) ? ST_SEED : ST_DONE;
        end
      end
      ST_SEED: begin
        en1  = 1'b1;
        busy = 1'b1;
        Xp0  = r_seed_p;
        Xs0  = r_seed_s;
        Xl0  = r_seed_l;
`ifdef KEYSTREAM_SEQ_WARMUP_EN
        w_next_state = ST_WARMUP;
`else
        w_next_state = ST_RUN;
`endif
      end
`ifdef KEYSTREAM_SEQ_WARMUP_EN
      ST_WARMUP: begin
        en1  = 1'b1;
        s    = 1'b1;
        busy = 1'b1;
        Xp0  = r_shadow_p;
        Xs0  = r_shadow_s;
        Xl0  = r_shadow_l;
        if (r_warm_cnt == c_warm_last) begin
          w_next_state = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        // On a stall the datapath reloads from shadow and recomputes the same state
        en1  = 1'b1;
        s    = w_adv;
        busy = 1'b1;
        Xp0  = r_shadow_p;
        Xs0  = r_shadow_s;
        Xl0  = r_shadow_l;
        if (w_adv && (r_loaded + 17'd1 == w_len_ext)) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        en1  = 1'b1;
        busy = 1'b1;
        Xp0  = r_shadow_p;
        Xs0  = r_shadow_s;
        Xl0  = r_shadow_l;
        if (w_hs && (r_sent + 17'd1 == w_len_ext)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= 16'd0;
      r_seed_p   <= 32'd0;
      r_seed_s   <= 32'd0;
      r_seed_l   <= 32'd0;
      r_shadow_p <= 32'd0;
      r_shadow_s <= 32'd0;
      r_shadow_l <= 32'd0;
      r_loaded   <= 17'd0;
      r_sent     <= 17'd0;
      r_ks_word  <= 32'd0;
      r_ks_valid <= 1'b0;
`ifdef KEYSTREAM_SEQ_WARMUP_EN
      r_warm_cnt <= 8'd0;
`endif
    end else begin
      r_state <= w_next_state;

      if (r_state == ST_IDLE && start) begin
        r_len    <= len;
        r_seed_p <= seed_p;
        r_seed_s <= seed_s;
        r_seed_l <= seed_l;
        r_loaded <= 17'd0;
        r_sent   <= 17'd0;
      end

      if (r_state == ST_SEED) begin
        r_shadow_p <= r_seed_p;
        r_shadow_s <= r_seed_s;
        r_shadow_l <= r_seed_l;
`ifdef KEYSTREAM_SEQ_WARMUP_EN
        r_warm_cnt <= 8'd0;
`endif
      end

`ifdef KEYSTREAM_SEQ_WARMUP_EN
      if (r_state == ST_WARMUP) begin
        r_shadow_p <= Xpn;
        r_shadow_s <= Xsn;
        r_shadow_l <= Xln;
        r_warm_cnt <= r_warm_cnt + 8'd1;
      end
`endif

      // A load takes priority over a simultaneous handshake clearing valid
      if (w_adv) begin
        r_shadow_p <= Xpn;
        r_shadow_s <= Xsn;
        r_shadow_l <= Xln;
        r_ks_word  <= Xpn ^ Xsn ^ Xln;
        r_ks_valid <= 1'b1;
        r_loaded   <= r_loaded + 17'd1;
      end else if (w_hs) begin
        r_ks_valid <= 1'b0;
      end

      if (w_hs) begin
        r_sent <= r_sent + 17'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keystream_sequencer.sv
// ============================================================================
// Module   : tb_keystream_sequencer
// Purpose  : Randomized bench for keystream_sequencer with an X+1 stub datapath
//            and a closed-form keystream reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keystream_sequencer;

  localparam int WC = 4;
`ifdef KEYSTREAM_SEQ_WARMUP_EN
  localparam int W = WC;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic [31:0] seed_p = 32'd0, seed_s = 32'd0, seed_l = 32'd0;
  logic [31:0] xp, xs, xl;
  logic        s, en1, ks_valid, busy, done;
  logic        ks_ready = 1'b1;
  logic [31:0] Xp0, Xs0, Xl0, ks_word;

  int total = 0;
  int bad = 0;
  logic [31:0] cur_sp, cur_ss, cur_sl;
  bit en1_seen, valid_seen;

  keystream_sequencer #(.WARMUP_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .seed_p(seed_p), .seed_s(seed_s), .seed_l(seed_l),
    .Xpn(xp), .Xsn(xs), .Xln(xl),
    .s(s), .en1(en1), .Xp0(Xp0), .Xs0(Xs0), .Xl0(Xl0),
    .ks_word(ks_word), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stub coupled-map datapath: each map steps by +1
  always_ff @(posedge clk) begin
    if (reset) begin
      xp <= 32'd0; xs <= 32'd0; xl <= 32'd0;
    end else if (en1) begin
      xp <= (s ? xp : Xp0) + 32'd1;
      xs <= (s ? xs : Xs0) + 32'd1;
      xl <= (s ? xl : Xl0) + 32'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word k (1-based) is the XOR of each map advanced W+k steps from its seed
  function automatic logic [31:0] model_word(input int k);
    logic [31:0] off;
    off = 32'(W + k);
    return (cur_sp + off) ^ (cur_ss + off) ^ (cur_sl + off);
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ks_word"}, ks_word, 0);
    check({tag, "_ks_valid"}, ks_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_s_en1"}, {s, en1}, 0);
    check({tag, "_x0"}, Xp0 | Xs0 | Xl0, 0);
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready low 5 cycles after first valid
  task automatic run(input logic [31:0] sp, ss, sl, input int n, input int mode,
                     input int abort_after, input bit poke);
    int c, got, fv, last_hs, budget;
    logic pv, pr;
    logic [31:0] pw;
    bit fin, do_abort;
    cur_sp = sp; cur_ss = ss; cur_sl = sl;
    got = 0; fv = -1; last_hs = -10; fin = 0; do_abort = 0;
    pv = 0; pr = 1; pw = 0;
    budget = W + 20 + n * 8;
    @(negedge clk);
    seed_p = sp; seed_s = ss; seed_l = sl; len = 16'(n); start = 1'b1; ks_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    check("busy_after_start", busy, 1);
    while (!fin) begin
      if (do_abort) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero_outputs("abort");
        valid_seen = 0;
        for (int i = 0; i < 2 * n + W + 4; i++) begin
          @(negedge clk);
          if (ks_valid || done || busy) valid_seen = 1;
        end
        check("abort_quiet", valid_seen, 0);
        ks_ready = 1'b1;
        return;
      end
      if (ks_valid && fv < 0) begin
        fv = c;
        check("first_valid_latency", c, W + 2);
      end
      if (pv && !pr) begin
        check("hold_valid", ks_valid, 1);
        check("hold_word", ks_word, pw);
      end
      if (done) begin
        check("done_word_count", got, n);
        check("done_after_last_hs", c - 1, last_hs);
        fin = 1;
      end else begin
        if (poke && c == 3) begin
          start = 1'b1; len = 16'(n + 5);
        end else if (poke && c == 4) begin
          start = 1'b0;
        end
        case (mode)
          1: ks_ready = ($urandom_range(0, 3) != 0);
          2: ks_ready = !(fv >= 0 && c < fv + 5);
          default: ks_ready = 1'b1;
        endcase
        if (mode == 2 && fv >= 0 && c <= fv + 5) begin
          check("stall_xp", xp, sp + 32'(W + 2));
          check("stall_xs", xs, ss + 32'(W + 2));
          check("stall_xl", xl, sl + 32'(W + 2));
        end
        if (ks_valid && ks_ready) begin
          check("word", ks_word, model_word(got + 1));
          got++;
          last_hs = c;
          if (abort_after != 0 && got == abort_after) do_abort = 1;
        end
        pv = ks_valid; pr = ks_ready; pw = ks_word;
        @(negedge clk);
        c++;
        if (c > budget) begin
          check("run_timeout", c, budget);
          fin = 1;
        end
      end
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    ks_ready = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("reset");

    // len = 0 goes straight to DONE without touching the datapath
    en1_seen = 0; valid_seen = 0;
    len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (en1) en1_seen = 1;
    if (ks_valid) valid_seen = 1;
    check("len0_done", done, 1);
    @(negedge clk);
    if (en1) en1_seen = 1;
    if (ks_valid) valid_seen = 1;
    check("len0_done_clear", done, 0);
    check("len0_en1_never", en1_seen, 0);
    check("len0_valid_never", valid_seen, 0);

    run(32'h10, 32'h20, 32'h30, 3, 0, 0, 0);
    run(32'h10, 32'h20, 32'h30, 4, 2, 0, 0);
    run(32'h10, 32'h20, 32'h30, 1, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      run($urandom, $urandom, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)),
          $urandom_range(1, 20), 1, 0, (i % 2) == 1);
    end

    // Reset mid-run, then a fresh run with identical seeds
    run(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 8, 0, 2, 0);
    run(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 2, 1, 0, 0);

    run(32'hDEAD_BEEF, 32'h0, 32'h7FFF_FFFF, 300, 0, 0, 0);

    // Reset and start asserted together: reset wins
    @(negedge clk);
    reset = 1'b1; start = 1'b1; len = 16'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_en1", en1, 0);
    repeat (3) @(negedge clk);
    check("rst_start_still_idle", {busy, ks_valid, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
